// File: rtl/sccb_init_sequencer.sv
`timescale 1ns/1ps
// ============================================================================
// sccb_init_sequencer
//
// Autonomous AXI4 write master that brings up a camera sensor through the
// SCCB master controller without CPU involvement. After a start pulse it:
//   1. writes the controller configuration region with a 2-beat burst
//      {1'b0, SLV_DVC_ADDR}, PRESCALER,
//   2. walks an external synchronous register ROM and, for every entry,
//      pushes a 3-beat SCCB write command (8'h03, sub_addr, data) into the
//      controller TX FIFO region.
// ROM entries:
//   16'hFFFF     end marker, sequence finishes
//   {8'hFE, n}   wait n * DELAY_UNIT_CYC clock cycles (n = 0 means no wait)
//   other        {sub_addr, data} register write
// After the last ROM index the sequence finishes even without an end marker.
//
// Optional feature macro: SCCB_INIT_RETRY_EN
//   defined     -> a non-OKAY response on a command burst re-issues the same
//                  entry up to 3 times; the 4th failure sets err_o
//   undefined   -> the first non-OKAY response sets err_o and finishes
//   Configuration burst errors always abort immediately.
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   start_i           1-cycle start pulse, honoured only while idle
//   rom_addr_o        ROM index; rom_data_i is valid one cycle later
//   rom_data_i        {sub_addr[15:8], data[7:0]}
//   m_aw*             AXI4 write address channel (master side)
//   m_w*              AXI4 write data channel (master side)
//   m_b*              AXI4 write response channel (m_bid_i is ignored)
//   busy_o            sequence in progress
//   done_o            sticky, sequence finished; cleared by the next start
//   err_o             sticky, non-OKAY response seen; cleared by next start
//   cmd_cnt_o         number of SCCB commands acknowledged OKAY
// All outputs are registered.
// ============================================================================
module sccb_init_sequencer #(
    parameter logic [31:0] IP_CONF_BASE_ADDR = 32'h2000_0000,
    parameter logic [31:0] IP_TX_BASE_ADDR   = 32'h2100_0000,
    parameter int          DATA_W            = 8,
    parameter int          ADDR_W            = 32,
    parameter int          MST_ID_W          = 5,
    parameter int          TRANS_DATA_LEN_W  = 8,
    parameter int          TRANS_RESP_W      = 2,
    parameter int          MST_ID            = 0,
    parameter logic [6:0]  SLV_DVC_ADDR      = 7'h21,
    parameter logic [7:0]  PRESCALER         = 8'd0,
    parameter int          ROM_ADDR_W        = 6,
    parameter logic [31:0] DELAY_UNIT_CYC    = 32'd125_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    output logic [ROM_ADDR_W-1:0]       rom_addr_o,
    input  logic [15:0]                 rom_data_i,
    output logic [MST_ID_W-1:0]         m_awid_o,
    output logic [ADDR_W-1:0]           m_awaddr_o,
    output logic [TRANS_DATA_LEN_W-1:0] m_awlen_o,
    output logic                        m_awvalid_o,
    input  logic                        m_awready_i,
    output logic [DATA_W-1:0]           m_wdata_o,
    output logic                        m_wlast_o,
    output logic                        m_wvalid_o,
    input  logic                        m_wready_i,
    input  logic [MST_ID_W-1:0]         m_bid_i,
    input  logic [TRANS_RESP_W-1:0]     m_bresp_i,
    input  logic                        m_bvalid_i,
    output logic                        m_bready_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [ROM_ADDR_W:0]         cmd_cnt_o
);

    typedef enum logic [3:0] {
        IDLE,
        CONF_AW,
        CONF_W,
        CONF_B,
        ROM_RD,
        DECODE,
        CMD_AW,
        CMD_W,
        CMD_B,
        DELAY,
        FIN
    } state_t;

    localparam logic [ROM_ADDR_W-1:0]       IDX_ONE   = {{(ROM_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ROM_ADDR_W:0]         CNT_ONE   = {{ROM_ADDR_W{1'b0}}, 1'b1};
    localparam logic [MST_ID_W-1:0]         MST_ID_V  = MST_ID_W'(MST_ID);
    localparam logic [ADDR_W-1:0]           CONF_ADDR = ADDR_W'(IP_CONF_BASE_ADDR);
    localparam logic [ADDR_W-1:0]           TX_ADDR   = ADDR_W'(IP_TX_BASE_ADDR);
    localparam logic [TRANS_DATA_LEN_W-1:0] CONF_LEN  = TRANS_DATA_LEN_W'(1);
    localparam logic [TRANS_DATA_LEN_W-1:0] CMD_LEN   = TRANS_DATA_LEN_W'(2);
    localparam logic [DATA_W-1:0]           CONF_B0   = DATA_W'({1'b0, SLV_DVC_ADDR});
    localparam logic [DATA_W-1:0]           CONF_B1   = DATA_W'(PRESCALER);
    localparam logic [DATA_W-1:0]           CMD_B0    = DATA_W'(8'h03);

    state_t                        state_q, state_n;
    logic [ROM_ADDR_W-1:0]         idx_q, idx_n;
    logic [1:0]                    beat_q, beat_n;
    logic [31:0]                   delay_q, delay_n;
    logic [7:0]                    sub_q, sub_n;
    logic [7:0]                    dat_q, dat_n;
    logic [MST_ID_W-1:0]           awid_q;
    logic [ADDR_W-1:0]             awaddr_q, awaddr_n;
    logic [TRANS_DATA_LEN_W-1:0]   awlen_q, awlen_n;
    logic                          awvalid_q, awvalid_n;
    logic [DATA_W-1:0]             wdata_q, wdata_n;
    logic                          wlast_q, wlast_n;
    logic                          wvalid_q, wvalid_n;
    logic                          bready_q, bready_n;
    logic                          busy_q, busy_n;
    logic                          done_q, done_n;
    logic                          err_q, err_n;
    logic [ROM_ADDR_W:0]           cmd_cnt_q, cmd_cnt_n;
    logic                          advance;
    logic                          resp_okay;
`ifdef SCCB_INIT_RETRY_EN
    logic [1:0]                    retry_q, retry_n;
`endif

    // The response ID carries no information for a single-ID master.
    logic unused_bid;
    assign unused_bid = ^m_bid_i;

    assign resp_okay = (m_bresp_i == '0);

    // State and datapath registers; every output is driven straight from here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            beat_q    <= '0;
            delay_q   <= '0;
            sub_q     <= '0;
            dat_q     <= '0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awvalid_q <= 1'b0;
            wdata_q   <= '0;
            wlast_q   <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cmd_cnt_q <= '0;
`ifdef SCCB_INIT_RETRY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_n;
            idx_q     <= idx_n;
            beat_q    <= beat_n;
            delay_q   <= delay_n;
            sub_q     <= sub_n;
            dat_q     <= dat_n;
            awid_q    <= MST_ID_V;
            awaddr_q  <= awaddr_n;
            awlen_q   <= awlen_n;
            awvalid_q <= awvalid_n;
            wdata_q   <= wdata_n;
            wlast_q   <= wlast_n;
            wvalid_q  <= wvalid_n;
            bready_q  <= bready_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            err_q     <= err_n;
            cmd_cnt_q <= cmd_cnt_n;
`ifdef SCCB_INIT_RETRY_EN
            retry_q   <= retry_n;
`endif
        end
    end

    // Next-state and next-output logic. Output registers are loaded one
    // cycle ahead so that each state sees its own outputs already asserted.
    always_comb begin
        state_n   = state_q;
        idx_n     = idx_q;
        beat_n    = beat_q;
        delay_n   = delay_q;
        sub_n     = sub_q;
        dat_n     = dat_q;
        awaddr_n  = awaddr_q;
        awlen_n   = awlen_q;
        awvalid_n = awvalid_q;
        wdata_n   = wdata_q;
        wlast_n   = wlast_q;
        wvalid_n  = wvalid_q;
        bready_n  = bready_q;
        done_n    = done_q;
        err_n     = err_q;
        cmd_cnt_n = cmd_cnt_q;
        advance   = 1'b0;
`ifdef SCCB_INIT_RETRY_EN
        retry_n   = retry_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_n   = CONF_AW;
                    done_n    = 1'b0;
                    err_n     = 1'b0;
                    cmd_cnt_n = '0;
                    idx_n     = '0;
                    awaddr_n  = CONF_ADDR;
                    awlen_n   = CONF_LEN;
                    awvalid_n = 1'b1;
                end
            end

            CONF_AW: begin
                if (m_awready_i) begin
                    awvalid_n = 1'b0;
                    wvalid_n  = 1'b1;
                    wdata_n   = CONF_B0;
                    wlast_n   = 1'b0;
                    beat_n    = 2'd0;
                    state_n   = CONF_W;
                end
            end

            CONF_W: begin
                if (m_wready_i) begin
                    if (beat_q == 2'd1) begin
                        wvalid_n = 1'b0;
                        wlast_n  = 1'b0;
                        bready_n = 1'b1;
                        state_n  = CONF_B;
                    end else begin
                        beat_n  = 2'd1;
                        wdata_n = CONF_B1;
                        wlast_n = 1'b1;
                    end
                end
            end

            CONF_B: begin
                if (m_bvalid_i) begin
                    bready_n = 1'b0;
                    if (resp_okay) begin
                        state_n = ROM_RD;
                    end else begin
                        err_n   = 1'b1;
                        state_n = FIN;
                    end
                end
            end

            // rom_addr_o already carries the index; data is sampled next cycle.
            ROM_RD: begin
                state_n = DECODE;
            end

            DECODE: begin
                if (rom_data_i == 16'hFFFF) begin
                    state_n = FIN;
                end else if (rom_data_i[15:8] == 8'hFE) begin
                    if (rom_data_i[7:0] == 8'd0) begin
                        advance = 1'b1;
                    end else begin
                        delay_n = 32'(rom_data_i[7:0]) * DELAY_UNIT_CYC;
                        state_n = DELAY;
                    end
                end else begin
                    sub_n     = rom_data_i[15:8];
                    dat_n     = rom_data_i[7:0];
                    awaddr_n  = TX_ADDR;
                    awlen_n   = CMD_LEN;
                    awvalid_n = 1'b1;
                    state_n   = CMD_AW;
`ifdef SCCB_INIT_RETRY_EN
                    retry_n   = '0;
`endif
                end
            end

            CMD_AW: begin
                if (m_awready_i) begin
                    awvalid_n = 1'b0;
                    wvalid_n  = 1'b1;
                    wdata_n   = CMD_B0;
                    wlast_n   = 1'b0;
                    beat_n    = 2'd0;
                    state_n   = CMD_W;
                end
            end

            CMD_W: begin
                if (m_wready_i) begin
                    case (beat_q)
                        2'd0: begin
                            beat_n  = 2'd1;
                            wdata_n = DATA_W'(sub_q);
                        end
                        2'd1: begin
                            beat_n  = 2'd2;
                            wdata_n = DATA_W'(dat_q);
                            wlast_n = 1'b1;
                        end
                        default: begin
                            wvalid_n = 1'b0;
                            wlast_n  = 1'b0;
                            bready_n = 1'b1;
                            state_n  = CMD_B;
                        end
                    endcase
                end
            end

            CMD_B: begin
                if (m_bvalid_i) begin
                    bready_n = 1'b0;
                    if (resp_okay) begin
                        cmd_cnt_n = cmd_cnt_q + CNT_ONE;
                        advance   = 1'b1;
                    end else begin
`ifdef SCCB_INIT_RETRY_EN
                        // Sub-address and data are still latched, so a retry
                        // goes straight back to the address phase.
                        if (retry_q != 2'd3) begin
                            retry_n   = retry_q + 2'd1;
                            awvalid_n = 1'b1;
                            state_n   = CMD_AW;
                        end else begin
                            err_n   = 1'b1;
                            state_n = FIN;
                        end
`else
                        err_n   = 1'b1;
                        state_n = FIN;
`endif
                    end
                end
            end

            // Leaves on the cycle the counter steps down to zero, so a load
            // of N keeps the sequencer here for exactly N cycles.
            DELAY: begin
                if (delay_q <= 32'd1) begin
                    delay_n = '0;
                    advance = 1'b1;
                end else begin
                    delay_n = delay_q - 32'd1;
                end
            end

            FIN: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Moving past an entry: the last ROM index ends the sequence.
        if (advance) begin
            if (&idx_q) begin
                state_n = FIN;
            end else begin
                idx_n   = idx_q + IDX_ONE;
                state_n = ROM_RD;
            end
        end

        if (state_n == FIN) begin
            done_n = 1'b1;
        end

        busy_n = (state_n != IDLE);
    end

    assign rom_addr_o  = idx_q;
    assign m_awid_o    = awid_q;
    assign m_awaddr_o  = awaddr_q;
    assign m_awlen_o   = awlen_q;
    assign m_awvalid_o = awvalid_q;
    assign m_wdata_o   = wdata_q;
    assign m_wlast_o   = wlast_q;
    assign m_wvalid_o  = wvalid_q;
    assign m_bready_o  = bready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign cmd_cnt_o   = cmd_cnt_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
`timescale 1ns/1ps
// ============================================================================
// tb_sccb_init_sequencer
//
// Bench for sccb_init_sequencer built with a 4-entry ROM (ROM_ADDR_W = 2) and
// a 10-cycle delay unit. The bench plays the AXI slave and the synchronous
// ROM. A transaction-level model turns the ROM contents and a per-burst
// response plan into the list of bursts the sequencer must issue, the final
// command count, the error flag and the number of busy cycles with an idle
// bus. A compare process checks every bus cycle against that list.
// ============================================================================
module tb_sccb_init_sequencer;

    localparam int          RAW     = 2;
    localparam int          UNIT    = 10;
    localparam logic [31:0] CONF_A  = 32'h2000_0000;
    localparam logic [31:0] TX_A    = 32'h2100_0000;
`ifdef SCCB_INIT_RETRY_EN
    localparam int          MAX_RETRY = 3;
`else
    localparam int          MAX_RETRY = 0;
`endif

    logic           clk;
    logic           rst;
    logic           start_i;
    logic [RAW-1:0] rom_addr_o;
    logic [15:0]    rom_data_i;
    logic [4:0]     m_awid_o;
    logic [31:0]    m_awaddr_o;
    logic [7:0]     m_awlen_o;
    logic           m_awvalid_o;
    logic           m_awready_i;
    logic [7:0]     m_wdata_o;
    logic           m_wlast_o;
    logic           m_wvalid_o;
    logic           m_wready_i;
    logic [4:0]     m_bid_i;
    logic [1:0]     m_bresp_i;
    logic           m_bvalid_i;
    logic           m_bready_o;
    logic           busy_o;
    logic           done_o;
    logic           err_o;
    logic [RAW:0]   cmd_cnt_o;

    sccb_init_sequencer #(
        .ROM_ADDR_W     (RAW),
        .DELAY_UNIT_CYC (UNIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .m_awid_o    (m_awid_o),
        .m_awaddr_o  (m_awaddr_o),
        .m_awlen_o   (m_awlen_o),
        .m_awvalid_o (m_awvalid_o),
        .m_awready_i (m_awready_i),
        .m_wdata_o   (m_wdata_o),
        .m_wlast_o   (m_wlast_o),
        .m_wvalid_o  (m_wvalid_o),
        .m_wready_i  (m_wready_i),
        .m_bid_i     (m_bid_i),
        .m_bresp_i   (m_bresp_i),
        .m_bvalid_i  (m_bvalid_i),
        .m_bready_o  (m_bready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .cmd_cnt_o   (cmd_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] rom_mem [4];
    logic [1:0]  resp_plan [16];
    bit          wtoggle;
    int          issue_no;

    logic [31:0] exp_addr  [$];
    int          exp_len   [$];
    logic [23:0] exp_beats [$];
    int          exp_cnt;
    bit          exp_err;
    int          exp_idle;

    bit          checking;
    int          bi;
    bit          aw_done;
    bit          w_done;
    int          beat;
    int          idle_cnt;
    bit          prev_wstall;
    bit          prev_awstall;
    logic [7:0]  prev_wdata;
    logic        prev_wlast;
    logic [31:0] prev_awaddr;
    logic [23:0] cur_beats;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Transaction-level model: list of bursts, command count, error flag and
    // idle-bus busy cycles (2 per ROM entry read + delay + 1 finishing cycle).
    function automatic void build_model();
        int issue;
        int decoded;
        int delays;
        int fails;
        bit stop;
        logic [15:0] e;
        exp_addr.delete();
        exp_len.delete();
        exp_beats.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
        issue   = 0;
        decoded = 0;
        delays  = 0;
        stop    = 1'b0;
        exp_addr.push_back(CONF_A);
        exp_len.push_back(1);
        exp_beats.push_back(24'h00_00_21);
        if (resp_plan[issue] != 2'b00) begin
            exp_err = 1'b1;
            stop    = 1'b1;
        end
        issue++;
        for (int i = 0; i < 4 && !stop; i++) begin
            e = rom_mem[i];
            decoded++;
            if (e == 16'hFFFF) break;
            if (e[15:8] == 8'hFE) begin
                delays += int'(e[7:0]) * UNIT;
                continue;
            end
            fails = 0;
            while (1) begin
                exp_addr.push_back(TX_A);
                exp_len.push_back(2);
                exp_beats.push_back({e[7:0], e[15:8], 8'h03});
                if (resp_plan[issue] == 2'b00) begin
                    issue++;
                    exp_cnt++;
                    break;
                end
                issue++;
                fails++;
                if (fails > MAX_RETRY) begin
                    exp_err = 1'b1;
                    stop    = 1'b1;
                    break;
                end
            end
        end
        exp_idle = 2 * decoded + delays + 1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_valids"}, {m_awvalid_o, m_wvalid_o, m_wlast_o, m_bready_o}, 0);
        check_output({tag, "_status"}, {busy_o, done_o, err_o}, 0);
        check_output({tag, "_awaddr"}, m_awaddr_o, 0);
        check_output({tag, "_awlen_id"}, {m_awlen_o, m_awid_o}, 0);
        check_output({tag, "_wdata"}, m_wdata_o, 0);
        check_output({tag, "_romaddr"}, rom_addr_o, 0);
        check_output({tag, "_cmdcnt"}, cmd_cnt_o, 0);
    endtask

    // AXI slave and synchronous ROM.
    initial begin
        logic [RAW-1:0] s_addr;
        bit s_wlast_hs;
        bit s_b_hs;
        m_awready_i = 1'b0;
        m_wready_i  = 1'b0;
        m_bvalid_i  = 1'b0;
        m_bresp_i   = 2'b00;
        m_bid_i     = '0;
        rom_data_i  = 16'h0000;
        forever begin
            @(negedge clk);
            s_addr     = rom_addr_o;
            s_wlast_hs = m_wvalid_o && m_wready_i && m_wlast_o;
            s_b_hs     = m_bvalid_i && m_bready_o;
            @(posedge clk);
            #1;
            rom_data_i = rom_mem[s_addr];
            if (rst) begin
                m_bvalid_i = 1'b0;
                issue_no   = 0;
            end else begin
                if (s_b_hs) m_bvalid_i = 1'b0;
                if (s_wlast_hs) begin
                    m_bvalid_i = 1'b1;
                    m_bresp_i  = resp_plan[issue_no];
                    m_bid_i    = 5'(issue_no + 7);
                    issue_no++;
                end
            end
            if (wtoggle) begin
                m_wready_i  = ~m_wready_i;
                m_awready_i = ~m_wready_i;
            end else begin
                m_wready_i  = 1'b1;
                m_awready_i = 1'b1;
            end
        end
    end

    // Per-cycle comparison of the bus against the model's burst list.
    always @(negedge clk) begin
        if (checking && !rst) begin
            if (busy_o && !m_awvalid_o && !m_wvalid_o && !m_bready_o) idle_cnt++;
            check_output("aw_w_overlap", {31'd0, m_awvalid_o & m_wvalid_o}, 0);
            if (prev_wstall) begin
                check_output("w_stall_valid", m_wvalid_o, 1);
                check_output("w_stall_data", {m_wlast_o, m_wdata_o}, {prev_wlast, prev_wdata});
            end
            if (prev_awstall) begin
                check_output("aw_stall_valid", m_awvalid_o, 1);
                check_output("aw_stall_addr", m_awaddr_o, prev_awaddr);
            end
            if (m_wvalid_o) begin
                check_output("w_after_aw", aw_done, 1);
                if (m_wready_i && bi < exp_beats.size()) begin
                    cur_beats = exp_beats[bi];
                    check_output("w_data", m_wdata_o, cur_beats[8*beat +: 8]);
                    check_output("w_last", m_wlast_o, (beat == exp_len[bi]) ? 1 : 0);
                    beat++;
                    if (m_wlast_o) w_done = 1'b1;
                end
            end
            if (m_awvalid_o && m_awready_i) begin
                check_output("aw_outstanding", aw_done, 0);
                if (bi < exp_addr.size()) begin
                    check_output("aw_addr", m_awaddr_o, exp_addr[bi]);
                    check_output("aw_len", m_awlen_o, exp_len[bi]);
                    check_output("aw_id", m_awid_o, 0);
                end else begin
                    check_output("extra_burst", bi, exp_addr.size());
                end
                aw_done = 1'b1;
                w_done  = 1'b0;
                beat    = 0;
            end
            if (m_bready_o) check_output("bready_after_wlast", w_done, 1);
            if (m_bready_o && m_bvalid_i) begin
                aw_done = 1'b0;
                w_done  = 1'b0;
                bi++;
            end
            prev_wstall  = m_wvalid_o && !m_wready_i;
            prev_wdata   = m_wdata_o;
            prev_wlast   = m_wlast_o;
            prev_awstall = m_awvalid_o && !m_awready_i;
            prev_awaddr  = m_awaddr_o;
        end
    end

    task automatic prepare_run();
        build_model();
        issue_no     = 0;
        bi           = 0;
        aw_done      = 1'b0;
        w_done       = 1'b0;
        beat         = 0;
        idle_cnt     = 0;
        prev_wstall  = 1'b0;
        prev_awstall = 1'b0;
    endtask

    // Runs one full sequence and compares the end state with the model and
    // with hand-computed literals.
    task automatic apply_stimulus(input string name, input bit extra_start,
                                  input int lit_bursts, input int lit_cnt, input bit lit_err);
        int cyc;
        prepare_run();
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        checking = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        @(negedge clk);
        check_output({name, "_start_awvalid"}, m_awvalid_o, 1);
        check_output({name, "_start_cleared"}, {busy_o, done_o, err_o, 29'(cmd_cnt_o)}, {3'b100, 29'd0});
        cyc = 0;
        while (!(done_o && !busy_o) && cyc < 2000) begin
            start_i = extra_start && (cyc == 12);
            @(negedge clk);
            cyc++;
        end
        start_i  = 1'b0;
        checking = 1'b0;
        check_output({name, "_finished"}, {31'd0, done_o && !busy_o}, 1);
        check_output({name, "_bursts"}, bi, exp_addr.size());
        check_output({name, "_bursts_lit"}, bi, lit_bursts);
        check_output({name, "_cmdcnt"}, cmd_cnt_o, exp_cnt);
        check_output({name, "_cmdcnt_lit"}, cmd_cnt_o, lit_cnt);
        check_output({name, "_err"}, err_o, exp_err);
        check_output({name, "_err_lit"}, err_o, lit_err);
        check_output({name, "_idle_cycles"}, idle_cnt, exp_idle);
        repeat (3) @(negedge clk);
        check_output({name, "_done_sticky"}, {done_o, busy_o}, 2'b10);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 16; i++) resp_plan[i] = 2'b00;
    endtask

    initial begin
        int k;
        rst      = 1'b1;
        start_i  = 1'b0;
        wtoggle  = 1'b0;
        checking = 1'b0;
        issue_no = 0;
        clear_plan();
        rom_mem = '{16'h1280, 16'h1100, 16'hFFFF, 16'h0000};
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Pin the model with hand-computed values.
        build_model();
        check_output("model_bursts", exp_addr.size(), 3);
        check_output("model_beats1", exp_beats[1], 24'h80_12_03);
        check_output("model_beats2", exp_beats[2], 24'h00_11_03);
        check_output("model_idle", exp_idle, 7);

        $display("[TB] basic sequence");
        apply_stimulus("basic", 1'b1, 3, 2, 1'b0);

        $display("[TB] stalled ready channels");
        wtoggle = 1'b1;
        apply_stimulus("stall", 1'b0, 3, 2, 1'b0);
        wtoggle = 1'b0;

        $display("[TB] delay entry");
        rom_mem = '{16'hFE03, 16'hFFFF, 16'h1234, 16'h5678};
        build_model();
        check_output("model_delay_idle", exp_idle, 35);
        apply_stimulus("delay", 1'b0, 1, 0, 1'b0);

        $display("[TB] zero delay and index wrap");
        rom_mem = '{16'h0A01, 16'hFE00, 16'h0C03, 16'h0D04};
        apply_stimulus("zdelay", 1'b0, 4, 3, 1'b0);
        rom_mem = '{16'h0A01, 16'h0B02, 16'h0C03, 16'h0D04};
        apply_stimulus("wrap", 1'b0, 5, 4, 1'b0);

        $display("[TB] error response on second command");
        rom_mem = '{16'h1280, 16'h1100, 16'h3A04, 16'hFFFF};
        resp_plan[2] = 2'b10;
        resp_plan[3] = 2'b10;
`ifdef SCCB_INIT_RETRY_EN
        apply_stimulus("cmd_err", 1'b0, 6, 3, 1'b0);
`else
        apply_stimulus("cmd_err", 1'b0, 3, 1, 1'b1);
`endif
        clear_plan();

        $display("[TB] error response on configuration burst");
        resp_plan[0] = 2'b11;
        apply_stimulus("conf_err", 1'b0, 1, 0, 1'b1);
        clear_plan();

        $display("[TB] reset during command data phase");
        rom_mem = '{16'h1280, 16'h1100, 16'hFFFF, 16'h0000};
        prepare_run();
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        checking = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        k = 0;
        while (!(m_wvalid_o && m_awaddr_o == TX_A) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_output("rst_reached_cmd_w", {31'd0, m_wvalid_o && m_awaddr_o == TX_A}, 1);
        checking = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        apply_stimulus("after_rst", 1'b0, 3, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
